// File: rtl/trigger_seq_ctrl.sv
// Shot sequencer for the time-of-flight trigger generator.
// Arms the generator, waits for detect_pls_1, captures pulse_tof into a
// small first-word-fall-through FIFO, then disarms for a dead time and re-arms.
// Optional feature: define TRIG_SEQ_TIMESTAMP_EN to store a 32-bit free-running
// timestamp with every result (rd_ts); otherwise rd_ts is tied to zero.
module trigger_seq_ctrl #(
  parameter int FIFO_AW    = 2,
  parameter int CNT_WIDTH  = 16,
  parameter int MIN_DISARM = 4
) (
  input  logic                 rxclk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic                 cfg_continuous,
  input  logic [CNT_WIDTH-1:0] cfg_num_shots,
  input  logic [31:0]          cfg_arm_timeout,
  input  logic [31:0]          cfg_rearm_delay,
  input  logic                 detect_pls_1,
  input  logic [31:0]          pulse_tof,
  output logic                 trig_enable,
  input  logic                 rd_en,
  output logic [31:0]          rd_data,
  output logic [31:0]          rd_ts,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] shot_cnt,
  output logic [CNT_WIDTH-1:0] timeout_cnt,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
`ifdef TRIG_SEQ_TIMESTAMP_EN
  localparam int FW = 64;
`else
  localparam int FW = 32;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, REARM} state_t;

  state_t               state;
  logic                 det_q, det_q_d;
  logic [31:0]          timer;
  logic [31:0]          dcnt;
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic [FW-1:0]        mem [DEPTH];
  logic [FW-1:0]        wdata;
  logic [FW-1:0]        head;
  logic                 trig_evt, timeout_hit, push, pop, full, push_ok, last_shot;
  logic [31:0]          rearm_len;
  logic [CNT_WIDTH-1:0] shot_inc, tmo_inc;

  assign trig_evt    = det_q & ~det_q_d;
  assign timeout_hit = (cfg_arm_timeout != '0) && (timer == cfg_arm_timeout - 32'd1);
  assign push        = (state == CAPTURE) && !cfg_stop;
  assign pop         = rd_en && rd_valid;
  assign full        = (count == (FIFO_AW+1)'(DEPTH));
  assign push_ok     = push && (!full || pop);
  assign shot_inc    = (shot_cnt == '1) ? shot_cnt : shot_cnt + 1'b1;
  assign tmo_inc     = (timeout_cnt == '1) ? timeout_cnt : timeout_cnt + 1'b1;
  assign rearm_len   = (cfg_rearm_delay < 32'(MIN_DISARM)) ? 32'(MIN_DISARM) : cfg_rearm_delay;
  // Compare one bit wider so a saturated shot_cnt cannot wrap into a false match.
  assign last_shot   = !cfg_continuous ||
                       ((cfg_num_shots != '0) &&
                        ((CNT_WIDTH+1)'(shot_cnt) + 1'b1 == (CNT_WIDTH+1)'(cfg_num_shots)));

  assign busy     = (state != IDLE);
  assign rd_valid = (count != '0);
  assign head     = mem[rd_ptr];

`ifdef TRIG_SEQ_TIMESTAMP_EN
  logic [31:0] ts;

  // Free-running timestamp, wraps at 2^32
  always_ff @(posedge rxclk) begin
    if (rst) ts <= '0;
    else     ts <= ts + 32'd1;
  end

  assign wdata   = {pulse_tof, ts};
  assign rd_data = head[63:32];
  assign rd_ts   = head[31:0];
`else
  assign wdata   = pulse_tof;
  assign rd_data = head;
  assign rd_ts   = '0;
`endif

  // Detect-pulse synchroniser and edge history
  always_ff @(posedge rxclk) begin
    if (rst) begin
      det_q   <= 1'b0;
      det_q_d <= 1'b0;
    end else begin
      det_q   <= detect_pls_1;
      det_q_d <= det_q;
    end
  end

  // Shot sequencer; trig_enable is registered alongside the state
  always_ff @(posedge rxclk) begin
    if (rst) begin
      state       <= IDLE;
      trig_enable <= 1'b0;
      done        <= 1'b0;
      shot_cnt    <= '0;
      timeout_cnt <= '0;
      overflow    <= 1'b0;
      timer       <= '0;
      dcnt        <= '0;
    end else begin
      done <= 1'b0;
      if (cfg_stop) begin
        state       <= IDLE;
        trig_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              shot_cnt    <= '0;
              timeout_cnt <= '0;
              overflow    <= 1'b0;
              timer       <= '0;
              state       <= ARMED;
              trig_enable <= 1'b1;
            end
          end
          ARMED: begin
            timer <= timer + 32'd1;
            if (trig_evt) begin
              state       <= CAPTURE;
              trig_enable <= 1'b0;
            end else if (timeout_hit) begin
              timeout_cnt <= tmo_inc;
              dcnt        <= rearm_len;
              state       <= REARM;
              trig_enable <= 1'b0;
            end
          end
          CAPTURE: begin
            shot_cnt <= shot_inc;
            if (push && !push_ok) overflow <= 1'b1;
            if (last_shot) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              dcnt  <= rearm_len;
              state <= REARM;
            end
          end
          REARM: begin
            if (dcnt == 32'd1) begin
              timer       <= '0;
              state       <= ARMED;
              trig_enable <= 1'b1;
            end else begin
              dcnt <= dcnt - 32'd1;
            end
          end
          default: begin
            state       <= IDLE;
            trig_enable <= 1'b0;
          end
        endcase
      end
    end
  end

  // Result FIFO storage and pointers; simultaneous push and pop on full keeps count
  always_ff @(posedge rxclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_seq_ctrl.sv
// Scoreboard bench for trigger_seq_ctrl: stimulus pushes expected FIFO results,
// a negedge monitor pops the FIFO and compares head data/timestamp.
module tb_trigger_seq_ctrl;

  logic        rxclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
  logic [15:0] cfg_num_shots = '0;
  logic [31:0] cfg_arm_timeout = '0, cfg_rearm_delay = '0;
  logic        detect_pls_1 = 1'b0;
  logic [31:0] pulse_tof = '0;
  logic        trig_enable;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data, rd_ts;
  logic        rd_valid, busy, done, overflow;
  logic [15:0] shot_cnt, timeout_cnt;

  always #4 rxclk = ~rxclk;

  trigger_seq_ctrl #(.FIFO_AW(2), .CNT_WIDTH(16), .MIN_DISARM(4)) dut (
    .rxclk(rxclk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_continuous(cfg_continuous), .cfg_num_shots(cfg_num_shots),
    .cfg_arm_timeout(cfg_arm_timeout), .cfg_rearm_delay(cfg_rearm_delay),
    .detect_pls_1(detect_pls_1), .pulse_tof(pulse_tof), .trig_enable(trig_enable),
    .rd_en(rd_en), .rd_data(rd_data), .rd_ts(rd_ts), .rd_valid(rd_valid),
    .busy(busy), .done(done), .shot_cnt(shot_cnt), .timeout_cnt(timeout_cnt),
    .overflow(overflow)
  );

  typedef struct { logic [31:0] tof; logic [31:0] ts; } exp_t;
  exp_t        exp_q[$];
  exp_t        sb_e;
  int          n_vec = 0, n_bad = 0;
  int          done_seen = 0;
  logic [31:0] cyc = '0;
  bit          rd_allow = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Cycle reference for expected timestamps (cleared by rst like the DUT counter)
  always @(posedge rxclk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  always @(negedge rxclk) if (!rst && done) done_seen++;

  // Monitor: pop whenever allowed and compare against the scoreboard
  always @(negedge rxclk) begin
    if (rst) rd_en = 1'b0;
    else begin
      rd_en = rd_allow && rd_valid;
      if (rd_en) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_unexpected: got entry 0x%0h, expected none", rd_data);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_tof", 64'(rd_data), 64'(sb_e.tof));
`ifdef TRIG_SEQ_TIMESTAMP_EN
          check("sb_ts", 64'(rd_ts), 64'(sb_e.ts));
`else
          check("sb_ts_zero", 64'(rd_ts), 64'd0);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic start_run(input logic cont, input logic [15:0] num,
                           input logic [31:0] tmo, input logic [31:0] rearm);
    cfg_continuous  = cont;
    cfg_num_shots   = num;
    cfg_arm_timeout = tmo;
    cfg_rearm_delay = rearm;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Returns one cycle into ARMED; low = disarmed cycles observed while waiting
  task automatic wait_arm(output int low);
    bit ok = 1'b0;
    low = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge rxclk);
      if (trig_enable) begin
        ok = 1'b1;
        break;
      end
      low++;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL arm_wait: trig_enable 0 after 2000 cycles, expected 1");
    end
    tick();
  endtask

  // Detect pulse raised now; CAPTURE occurs two cycles later
  task automatic do_shot(input logic [31:0] tof, input bit keep, input bit pop_now);
    exp_t e;
    pulse_tof    = tof;
    detect_pls_1 = 1'b1;
    if (keep) begin
      e.tof = tof;
      e.ts  = cyc + 32'd2;
      exp_q.push_back(e);
    end
    tick();
    tick();
    detect_pls_1 = 1'b0;
    if (pop_now) rd_allow = 1'b1;
    tick();
    if (pop_now) rd_allow = 1'b0;
  endtask

  task automatic drain(input string name);
    rd_allow = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge rxclk);
      if (!rd_valid && exp_q.size() == 0) break;
    end
    check(name, {63'(exp_q.size()), rd_valid}, 64'd0);
    rd_allow = 1'b0;
    tick();
  endtask

  int low, d0;

  initial begin
    repeat (3) tick();
    @(negedge rxclk);
    check("reset_flags", {trig_enable, rd_valid, busy, done, overflow, shot_cnt, timeout_cnt}, 64'd0);
    check("reset_rd", {rd_data, rd_ts}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // T1 single shot
    rd_allow = 1'b1;
    d0 = done_seen;
    start_run(1'b0, 16'd0, 32'd0, 32'd0);
    wait_arm(low);
    repeat (40) tick();
    do_shot(32'h1234, 1'b1, 1'b0);
    @(negedge rxclk);
    check("t1_trig_low", 64'(trig_enable), 64'd0);
    tick();
    repeat (4) tick();
    @(negedge rxclk);
    check("t1_shot_cnt", 64'(shot_cnt), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_done", 64'(done_seen - d0), 64'd1);
    tick();
    drain("t1_drain");

    // T2 three-shot run with 10-cycle dead time
    d0 = done_seen;
    start_run(1'b1, 16'd3, 32'd0, 32'd10);
    wait_arm(low);
    do_shot(32'h0000_00A1, 1'b1, 1'b0);
    wait_arm(low);
    check("t2_gap1", 64'(low >= 10), 64'd1);
    do_shot(32'h0000_00A2, 1'b1, 1'b0);
    wait_arm(low);
    check("t2_gap2", 64'(low >= 10), 64'd1);
    do_shot(32'h0000_00A3, 1'b1, 1'b0);
    repeat (3) tick();
    @(negedge rxclk);
    check("t2_done", 64'(done_seen - d0), 64'd1);
    check("t2_shot_cnt", 64'(shot_cnt), 64'd3);
    check("t2_busy", 64'(busy), 64'd0);
    tick();
    drain("t2_drain");

    // T3 timeouts: 100 armed + 4 disarmed per period, stop at 450 cycles
    d0 = done_seen;
    start_run(1'b1, 16'd0, 32'd100, 32'd0);
    repeat (449) tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    @(negedge rxclk);
    check("t3_timeout_cnt", 64'(timeout_cnt), 64'd4);
    check("t3_shot_cnt", 64'(shot_cnt), 64'd0);
    check("t3_fifo_empty", 64'(rd_valid), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_no_done", 64'(done_seen - d0), 64'd0);
    tick();

    // T4 overflow: five shots into depth four, no reads
    rd_allow = 1'b0;
    d0 = done_seen;
    start_run(1'b1, 16'd5, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      wait_arm(low);
      do_shot(32'h10 + 32'(i), (i < 4), 1'b0);
    end
    repeat (3) tick();
    @(negedge rxclk);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_shot_cnt", 64'(shot_cnt), 64'd5);
    check("t4_done", 64'(done_seen - d0), 64'd1);
    tick();
    // Push while full with a same-cycle pop: accepted, no drop
    start_run(1'b0, 16'd0, 32'd0, 32'd0);
    wait_arm(low);
    do_shot(32'h15, 1'b1, 1'b1);
    repeat (2) tick();
    @(negedge rxclk);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    check("t4_full_valid", 64'(rd_valid), 64'd1);
    tick();
    drain("t4_drain");

    // T5 detect on the timeout cycle wins
    rd_allow = 1'b1;
    d0 = done_seen;
    start_run(1'b0, 16'd0, 32'd20, 32'd0);
    wait_arm(low);
    repeat (17) tick();
    do_shot(32'h55, 1'b1, 1'b0);
    repeat (3) tick();
    @(negedge rxclk);
    check("t5_timeout_cnt", 64'(timeout_cnt), 64'd0);
    check("t5_shot_cnt", 64'(shot_cnt), 64'd1);
    check("t5_done", 64'(done_seen - d0), 64'd1);
    tick();
    drain("t5_drain");

    // T5 start and stop together: stays idle
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    repeat (2) tick();
    @(negedge rxclk);
    check("t5_start_stop", {busy, trig_enable}, 64'd0);
    tick();

    // T5 reset while armed with a result held in the FIFO
    rd_allow = 1'b0;
    start_run(1'b1, 16'd0, 32'd0, 32'd0);
    wait_arm(low);
    do_shot(32'h66, 1'b1, 1'b0);
    wait_arm(low);
    rst = 1'b1;
    tick();
    @(negedge rxclk);
    check("t5_rst_flags", {trig_enable, rd_valid, busy, done, overflow, shot_cnt, timeout_cnt}, 64'd0);
    check("t5_rst_rd", {rd_data, rd_ts}, 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

endmodule
